ram_1p_arbiter: RTL and testbench

Two-port to single-port arbiter that shares the 32-bit, 1-cycle-latency single-port RAM between the Ibex instruction-fetch port and data port. It decides who accesses the RAM each cycle, forwards the request, and routes the single-cycle read response back to the granted requester. Requests outside the RAM window get an error response without touching the RAM. It sits between the core's instr/data bus interfaces and the RAM instance.

---
 rtl/ram_1p_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_ram_1p_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_1p_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_1p_arbiter
// Purpose  : Lets the instruction-fetch port and the data port share one
//            32-bit single-port RAM that answers one cycle after a request.
//            Each cycle it grants at most one port and forwards that port's
//            request to the RAM. It routes the RAM's read response back to
//            the port that was granted. An address outside the RAM window
//            still gets a grant, but the RAM is not accessed; instead the
//            port gets an error response one cycle later.
// Options  : RAM_ARB_FIXED_PRIO_EN - when defined, the data port always wins
//            contention and no round-robin pointer is built. When undefined,
//            contention is resolved round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module ram_1p_arbiter #(
  parameter int unsigned Depth    = 16384,        // RAM words, power of two
  parameter logic [31:0] BaseAddr = 32'h0000_0000 // byte address of word 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,

  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,

  output logic        ram_req_o,
  output logic        ram_we_o,
  output logic [3:0]  ram_be_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  input  logic        ram_rvalid_i,
  input  logic [31:0] ram_rdata_i
);

  // Size of the RAM window in bytes. It is held in 33 bits so that the
  // window size itself can never wrap to zero.
  localparam logic [32:0] C_WINDOW_BYTES = 33'(Depth) * 33'd4;

  // Response state. It remembers which port, if any, was granted last cycle
  // and whether that access went to the RAM or was an error.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_RESP_I = 3'd1;
  localparam logic [2:0] ST_RESP_D = 3'd2;
  localparam logic [2:0] ST_ERR_I  = 3'd3;
  localparam logic [2:0] ST_ERR_D  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic        gnt_instr, gnt_data, gnt_any;
  logic [31:0] sel_addr, sel_offset;
  logic        sel_in_range;

`ifdef RAM_ARB_FIXED_PRIO_EN
  // Fixed priority: the data port always wins contention. Reset holds off
  // both grants.
  always_comb begin
    gnt_instr = 1'b0;
    gnt_data  = 1'b0;
    if (rst_ni) begin
      gnt_data  = data_req_i;
      gnt_instr = instr_req_i & ~data_req_i;
    end
  end
`else
  // Last-grant pointer: 1 means the data port was granted most recently.
  logic last_data_q, last_data_d;

  // Round-robin: under contention, grant the port the pointer does not name.
  // Reset holds off both grants.
  always_comb begin
    gnt_instr = 1'b0;
    gnt_data  = 1'b0;
    if (rst_ni) begin
      if (instr_req_i && data_req_i) begin
        if (last_data_q) begin
          gnt_instr = 1'b1;
        end else begin
          gnt_data = 1'b1;
        end
      end else begin
        gnt_instr = instr_req_i;
        gnt_data  = data_req_i;
      end
    end
  end

  // The pointer follows every grant; with no grant it keeps its value.
  always_comb begin
    last_data_d = last_data_q;
    if (gnt_instr || gnt_data) begin
      last_data_d = gnt_data;
    end
  end

  // Pointer register. It resets to DATA so that INSTR wins the first
  // contention.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_data_q <= 1'b1;
    end else begin
      last_data_q <= last_data_d;
    end
  end
`endif

  assign gnt_any     = gnt_instr | gnt_data;
  assign instr_gnt_o = gnt_instr;
  assign data_gnt_o  = gnt_data;

  // Window check on the granted port's address. Because BaseAddr is aligned
  // to the window size, a single unsigned compare of the offset covers both
  // bounds: any address below BaseAddr wraps to a large offset.
  always_comb begin
    sel_addr     = gnt_data ? data_addr_i : instr_addr_i;
    sel_offset   = sel_addr - BaseAddr;
    sel_in_range = ({1'b0, sel_offset} < C_WINDOW_BYTES);
  end

  // Forward the granted request to the RAM. An instruction fetch is always
  // a full-word read.
  always_comb begin
    ram_req_o   = 1'b0;
    ram_we_o    = 1'b0;
    ram_be_o    = 4'h0;
    ram_addr_o  = 32'h0;
    ram_wdata_o = 32'h0;
    if (gnt_any && sel_in_range) begin
      ram_req_o  = 1'b1;
      ram_addr_o = sel_offset;
      if (gnt_data) begin
        ram_we_o    = data_we_i;
        ram_be_o    = data_be_i;
        ram_wdata_o = data_wdata_i;
      end else begin
        ram_be_o = 4'hF;
      end
    end
  end

  // Next response state: decided entirely by this cycle's grant.
  always_comb begin
    state_d = ST_IDLE;
    if (gnt_instr) begin
      state_d = sel_in_range ? ST_RESP_I : ST_ERR_I;
    end else if (gnt_data) begin
      state_d = sel_in_range ? ST_RESP_D : ST_ERR_D;
    end
  end

  // Response state register. Reset drops any pending response.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Drive the response outputs from the response state. In IDLE the RAM's
  // rvalid is ignored, so a stray response that arrives after a reset is
  // dropped.
  always_comb begin
    instr_rvalid_o = 1'b0;
    instr_rdata_o  = 32'h0;
    instr_err_o    = 1'b0;
    data_rvalid_o  = 1'b0;
    data_rdata_o   = 32'h0;
    data_err_o     = 1'b0;
    case (state_q)
      ST_RESP_I: begin
        instr_rvalid_o = ram_rvalid_i;
        instr_rdata_o  = ram_rdata_i;
      end
      ST_RESP_D: begin
        data_rvalid_o = ram_rvalid_i;
        data_rdata_o  = ram_rdata_i;
      end
      ST_ERR_I: begin
        instr_rvalid_o = 1'b1;
        instr_err_o    = 1'b1;
      end
      ST_ERR_D: begin
        data_rvalid_o = 1'b1;
        data_err_o    = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_1p_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_1p_arbiter
// Purpose  : Directed self-checking bench for ram_1p_arbiter. It includes a
//            behavioural single-port RAM with one-cycle read latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_1p_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i, data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  logic        ram_req_o, ram_we_o;
  logic [3:0]  ram_be_o;
  logic [31:0] ram_addr_o, ram_wdata_o;
  logic        ram_rvalid_i = 1'b0;
  logic [31:0] ram_rdata_i  = 32'h0;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] mem [0:16383];
  bit          mem_init = 1'b0;

  ram_1p_arbiter #(.Depth(16384), .BaseAddr(32'h0000_0000)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
    .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
    .ram_rvalid_i(ram_rvalid_i), .ram_rdata_i(ram_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural RAM: it is preloaded on the first edge, reads the old word
  // and applies byte-enabled writes.
  always @(posedge clk_i) begin
    if (!mem_init) begin
      for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
      mem[2]   = 32'h0000_A103;
      mem_init = 1'b1;
    end
    ram_rvalid_i <= ram_req_o;
    if (ram_req_o) begin
      ram_rdata_i <= mem[ram_addr_o[15:2]];
      if (ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (ram_be_o[b]) mem[ram_addr_o[15:2]][8*b +: 8] = ram_wdata_o[8*b +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  bit exp_i [4];
  bit prev_i;
  bit post_rst_i;

  initial begin
    rst_ni = 1'b0; instr_req_i = 1'b0; instr_addr_i = 32'h0;
    data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0;
    data_addr_i = 32'h0; data_wdata_i = 32'h0;
`ifdef RAM_ARB_FIXED_PRIO_EN
    exp_i = '{0, 0, 0, 0};
    post_rst_i = 1'b0;
`else
    exp_i = '{1, 0, 1, 0};
    post_rst_i = 1'b1;
`endif
    tick(); tick();

    // While reset is held, requests must not be granted.
    instr_req_i = 1'b1; instr_addr_i = 32'h8; data_req_i = 1'b1; data_addr_i = 32'h3FC;
    #1;
    chk("rst_instr_gnt", 32'(instr_gnt_o), 32'h0);
    chk("rst_data_gnt", 32'(data_gnt_o), 32'h0);
    chk("rst_ram_req", 32'(ram_req_o), 32'h0);
    chk("rst_instr_rvalid", 32'(instr_rvalid_o), 32'h0);
    chk("rst_data_rvalid", 32'(data_rvalid_o), 32'h0);
    tick();

    // A single instruction fetch from word 2.
    rst_ni = 1'b1; data_req_i = 1'b0;
    #1;
    chk("i_gnt", 32'(instr_gnt_o), 32'h1);
    chk("i_d_gnt", 32'(data_gnt_o), 32'h0);
    chk("i_ram_req", 32'(ram_req_o), 32'h1);
    chk("i_ram_addr", ram_addr_o, 32'h8);
    chk("i_ram_we", 32'(ram_we_o), 32'h0);
    chk("i_ram_be", 32'(ram_be_o), 32'hF);
    tick();
    instr_req_i = 1'b0;
    #1;
    chk("i_rvalid", 32'(instr_rvalid_o), 32'h1);
    chk("i_rdata", instr_rdata_o, 32'h0000_A103);
    chk("i_err", 32'(instr_err_o), 32'h0);
    chk("i_d_rvalid", 32'(data_rvalid_o), 32'h0);

    // A data byte write, then a read-back of the same word.
    data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'b0001;
    data_addr_i = 32'h3FC; data_wdata_i = 32'h0000_00AB;
    #1;
    chk("w_gnt", 32'(data_gnt_o), 32'h1);
    chk("w_ram_we", 32'(ram_we_o), 32'h1);
    chk("w_ram_be", 32'(ram_be_o), 32'h1);
    chk("w_ram_wdata", ram_wdata_o, 32'hAB);
    chk("w_ram_addr", ram_addr_o, 32'h3FC);
    tick();
    data_we_i = 1'b0; data_be_i = 4'hF; data_wdata_i = 32'h0;
    #1;
    chk("r_gnt", 32'(data_gnt_o), 32'h1);
    chk("r_ram_we", 32'(ram_we_o), 32'h0);
    chk("w_rvalid", 32'(data_rvalid_o), 32'h1);
    chk("w_err", 32'(data_err_o), 32'h0);
    tick();
    data_req_i = 1'b0;
    #1;
    chk("r_rvalid", 32'(data_rvalid_o), 32'h1);
    chk("r_rdata", data_rdata_o, 32'h0000_00AB);
    chk("r_i_rvalid", 32'(instr_rvalid_o), 32'h0);

    // Both ports request for four consecutive cycles.
    instr_addr_i = 32'h8; data_addr_i = 32'h3FC;
    for (int k = 0; k < 4; k++) begin
      instr_req_i = 1'b1; data_req_i = 1'b1;
      #1;
      chk($sformatf("cont%0d_i_gnt", k), 32'(instr_gnt_o), 32'(exp_i[k]));
      chk($sformatf("cont%0d_d_gnt", k), 32'(data_gnt_o), 32'(!exp_i[k]));
      if (k > 0) begin
        chk($sformatf("cont%0d_i_rv", k), 32'(instr_rvalid_o), 32'(prev_i));
        chk($sformatf("cont%0d_d_rv", k), 32'(data_rvalid_o), 32'(!prev_i));
        chk($sformatf("cont%0d_rdata", k), prev_i ? instr_rdata_o : data_rdata_o,
            prev_i ? 32'h0000_A103 : 32'h0000_00AB);
      end
      prev_i = exp_i[k];
      tick();
    end
    instr_req_i = 1'b0; data_req_i = 1'b0;
    #1;
    chk("cont_last_i_rv", 32'(instr_rvalid_o), 32'(prev_i));
    chk("cont_last_d_rv", 32'(data_rvalid_o), 32'(!prev_i));

    // Reads at the edge of the window: the last word is in range, the
    // first word past the window is not.
    data_req_i = 1'b1; data_addr_i = 32'h0000_FFFC;
    #1;
    chk("edge_in_ram_req", 32'(ram_req_o), 32'h1);
    chk("edge_in_ram_addr", ram_addr_o, 32'h0000_FFFC);
    tick();
    data_addr_i = 32'h0001_0000;
    #1;
    chk("oor_d_gnt", 32'(data_gnt_o), 32'h1);
    chk("oor_ram_req", 32'(ram_req_o), 32'h0);
    chk("edge_in_err", 32'(data_err_o), 32'h0);
    tick();
    data_req_i = 1'b0; instr_req_i = 1'b1; instr_addr_i = 32'hFFFF_FFFC;
    #1;
    chk("oor_d_rvalid", 32'(data_rvalid_o), 32'h1);
    chk("oor_d_err", 32'(data_err_o), 32'h1);
    chk("oor_d_rdata", data_rdata_o, 32'h0);
    chk("oor_i_gnt", 32'(instr_gnt_o), 32'h1);
    chk("oor_i_ram_req", 32'(ram_req_o), 32'h0);
    tick();
    instr_req_i = 1'b0;
    #1;
    chk("oor_i_rvalid", 32'(instr_rvalid_o), 32'h1);
    chk("oor_i_err", 32'(instr_err_o), 32'h1);
    chk("oor_d_rvalid2", 32'(data_rvalid_o), 32'h0);

    // Reset while an instruction response is pending.
    instr_req_i = 1'b1; instr_addr_i = 32'h8;
    #1;
    chk("pr_i_gnt", 32'(instr_gnt_o), 32'h1);
    tick();
    rst_ni = 1'b0; data_req_i = 1'b1; data_addr_i = 32'h3FC;
    #1;
    chk("pr_rst_i_gnt", 32'(instr_gnt_o), 32'h0);
    chk("pr_rst_d_gnt", 32'(data_gnt_o), 32'h0);
    chk("pr_rst_ram_req", 32'(ram_req_o), 32'h0);
    tick();
    chk("pr_i_rvalid", 32'(instr_rvalid_o), 32'h0);
    chk("pr_i_rdata", instr_rdata_o, 32'h0);
    chk("pr_d_rvalid", 32'(data_rvalid_o), 32'h0);
    rst_ni = 1'b1;
    #1;
    chk("post_rst_i_gnt", 32'(instr_gnt_o), 32'(post_rst_i));
    chk("post_rst_d_gnt", 32'(data_gnt_o), 32'(!post_rst_i));
    tick();
    instr_req_i = 1'b0; data_req_i = 1'b0;
    #1;
    chk("post_rst_rdata", post_rst_i ? instr_rdata_o : data_rdata_o,
        post_rst_i ? 32'h0000_A103 : 32'h0000_00AB);
    tick();
    chk("idle_i_rvalid", 32'(instr_rvalid_o), 32'h0);
    chk("idle_d_rvalid", 32'(data_rvalid_o), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
